freq_stepper: RTL and testbench

- Parametrised successor to the key-driven frequency selector.
- Turns debounced up/down key levels into a DDS frequency tuning word (FTW) and a matching integer frequency in Hz.
- Adds fine/coarse step, hold-to-auto-repeat, hard clamping at both bounds, a preset reload and a one-cycle update strobe.
- Sits between the key debouncer and the DDS phase accumulator / LCD readout.

---
 rtl/freq_pkg.sv | 39 +++
 rtl/key_repeat.sv | 146 ++++++++++++++
 rtl/freq_stepper.sv | 150 +++++++++++++++
 tb/tb_freq_stepper.sv | 253 +++++++++++++++++++++++++
 4 files changed

// File: rtl/freq_pkg.sv
// -----------------------------------------------------------------------------
// freq_pkg
// Shared constants and types for the key-driven DDS frequency stepper.
//   - Default frequency plan for a 50 MHz clock (Hz bounds, step, FTW values)
//   - Auto-repeat timing defaults (500 ms hold, 100 ms repeat)
//   - Key FSM state encoding
//   - Helpers to derive the step count and pick the larger of two ints
// -----------------------------------------------------------------------------
package freq_pkg;

   localparam int DEF_FTW_W      = 32;
   localparam int DEF_HZ_W       = 20;
   localparam int DEF_MIN_HZ     = 20000;
   localparam int DEF_MAX_HZ     = 50000;
   localparam int DEF_STEP_HZ    = 2000;
   localparam int DEF_MIN_FTW    = 1717987;   // 20 kHz at 50 MHz, 2^32 scale
   localparam int DEF_STEP_FTW   = 171799;    // 2 kHz at 50 MHz, 2^32 scale
   localparam int DEF_COARSE_MUL = 5;
   localparam int DEF_HOLD_CYC   = 25000000;  // 500 ms
   localparam int DEF_REPEAT_CYC = 5000000;   // 100 ms

   typedef enum logic [1:0] {
      ST_IDLE   = 2'd0,
      ST_HOLD   = 2'd1,
      ST_REPEAT = 2'd2,
      ST_LOCK   = 2'd3
   } kr_state_e;

   // Number of fine steps between the two bounds; the span must divide evenly.
   function automatic int calc_nsteps(input int min_hz, input int max_hz,
                                      input int step_hz);
      return (max_hz - min_hz) / step_hz;
   endfunction

   function automatic int max_int(input int a, input int b);
      return (a > b) ? a : b;
   endfunction

endpackage

// File: rtl/key_repeat.sv
// -----------------------------------------------------------------------------
// key_repeat
// Turns debounced up/down key levels into registered single-cycle step pulses,
// with a hold delay before auto-repeat and a lockout while both keys are down.
// Ports:
//   clk_i       in   system clock
//   rst_n_i     in   asynchronous active-low reset
//   up_i        in   debounced up-key level
//   down_i      in   debounced down-key level
//   preset_i    in   preset pulse; aborts any hold, no step issued
//   step_up_o   out  one-cycle pulse: step up
//   step_dn_o   out  one-cycle pulse: step down
// -----------------------------------------------------------------------------
module key_repeat
   import freq_pkg::*;
#(
   parameter int HOLD_CYC   = DEF_HOLD_CYC,
   parameter int REPEAT_CYC = DEF_REPEAT_CYC
)(
   input  logic clk_i,
   input  logic rst_n_i,
   input  logic up_i,
   input  logic down_i,
   input  logic preset_i,
   output logic step_up_o,
   output logic step_dn_o
);

   localparam int TMR_W = $clog2(max_int(HOLD_CYC, REPEAT_CYC) + 1);
   localparam logic [TMR_W-1:0] C_HOLD_LAST   = TMR_W'(HOLD_CYC - 1);
   localparam logic [TMR_W-1:0] C_REPEAT_LAST = TMR_W'(REPEAT_CYC - 1);

   kr_state_e        r_state, w_state_next;
   logic [TMR_W-1:0] r_timer, w_timer_next;
   logic             r_dir_up, w_dir_up_next;
   logic             r_step_up, r_step_dn;
   logic             w_step_up_next, w_step_dn_next;
   logic             w_fire, w_fire_up;

   logic w_both, w_any, w_held;
   assign w_both = up_i & down_i;
   assign w_any  = up_i | down_i;
   // Level of the key that started the current hold.
   assign w_held = r_dir_up ? up_i : down_i;

   // State register (also registers the step pulses for a clean 2-cycle path)
   always_ff @(posedge clk_i or negedge rst_n_i) begin
      if (!rst_n_i) begin
         r_state   <= ST_IDLE;
         r_timer   <= '0;
         r_dir_up  <= 1'b0;
         r_step_up <= 1'b0;
         r_step_dn <= 1'b0;
      end else begin
         r_state   <= w_state_next;
         r_timer   <= w_timer_next;
         r_dir_up  <= w_dir_up_next;
         r_step_up <= w_step_up_next;
         r_step_dn <= w_step_dn_next;
      end
   end

   // Next-state logic
   always_comb begin
      w_state_next  = r_state;
      w_timer_next  = r_timer;
      w_dir_up_next = r_dir_up;
      if (preset_i) begin
         // A key still down after a preset must be released before it counts.
         w_state_next = w_any ? ST_LOCK : ST_IDLE;
         w_timer_next = '0;
      end else begin
         case (r_state)
            ST_IDLE: begin
               w_timer_next = '0;
               if (w_both) begin
                  w_state_next = ST_LOCK;
               end else if (w_any) begin
                  w_state_next  = ST_HOLD;
                  w_dir_up_next = up_i;
               end
            end
            ST_HOLD: begin
               if (w_both) begin
                  w_state_next = ST_LOCK;
                  w_timer_next = '0;
               end else if (!w_held) begin
                  w_state_next = ST_IDLE;
                  w_timer_next = '0;
               end else if (r_timer == C_HOLD_LAST) begin
                  w_state_next = ST_REPEAT;
                  w_timer_next = '0;
               end else begin
                  w_timer_next = r_timer + 1'b1;
               end
            end
            ST_REPEAT: begin
               if (w_both) begin
                  w_state_next = ST_LOCK;
                  w_timer_next = '0;
               end else if (!w_held) begin
                  w_state_next = ST_IDLE;
                  w_timer_next = '0;
               end else if (r_timer == C_REPEAT_LAST) begin
                  w_timer_next = '0;
               end else begin
                  w_timer_next = r_timer + 1'b1;
               end
            end
            ST_LOCK: begin
               w_timer_next = '0;
               if (!w_any) begin
                  w_state_next = ST_IDLE;
               end
            end
            default: begin
               w_state_next = ST_IDLE;
               w_timer_next = '0;
            end
         endcase
      end
   end

   // Output logic: step pulses for the next cycle
   always_comb begin
      w_fire    = 1'b0;
      w_fire_up = r_dir_up;
      if (!preset_i) begin
         case (r_state)
            ST_IDLE: begin
               w_fire    = w_any & ~w_both;
               w_fire_up = up_i;
            end
            ST_HOLD:   w_fire = ~w_both & w_held & (r_timer == C_HOLD_LAST);
            ST_REPEAT: w_fire = ~w_both & w_held & (r_timer == C_REPEAT_LAST);
            default:   w_fire = 1'b0;
         endcase
      end
      w_step_up_next = w_fire & w_fire_up;
      w_step_dn_next = w_fire & ~w_fire_up;
   end

   assign step_up_o = r_step_up;
   assign step_dn_o = r_step_dn;

endmodule

// File: rtl/freq_stepper.sv
// -----------------------------------------------------------------------------
// freq_stepper
// Keeps a step index plus lockstep FTW / Hz accumulators driven by key steps,
// with fine/coarse step size, hard clamping at both bounds and a preset reload.
// Ports:
//   clk_i       in   system clock, 50 MHz
//   rst_n_i     in   asynchronous active-low reset
//   up_i        in   debounced up-key level
//   down_i      in   debounced down-key level
//   coarse_i    in   1 selects coarse step (sampled when a step is applied)
//   preset_i    in   single-cycle pulse; reload the lower bound
//   ftw_o       out  DDS tuning word
//   freq_hz_o   out  current frequency in Hz
//   at_min_o    out  index is 0
//   at_max_o    out  index is at the top step
//   upd_o       out  one-cycle pulse when ftw_o changes
// -----------------------------------------------------------------------------
module freq_stepper
   import freq_pkg::*;
#(
   parameter int FTW_W      = DEF_FTW_W,
   parameter int HZ_W       = DEF_HZ_W,
   parameter int MIN_HZ     = DEF_MIN_HZ,
   parameter int MAX_HZ     = DEF_MAX_HZ,
   parameter int STEP_HZ    = DEF_STEP_HZ,
   parameter int MIN_FTW    = DEF_MIN_FTW,
   parameter int STEP_FTW   = DEF_STEP_FTW,
   parameter int COARSE_MUL = DEF_COARSE_MUL,
   parameter int HOLD_CYC   = DEF_HOLD_CYC,
   parameter int REPEAT_CYC = DEF_REPEAT_CYC
)(
   input  logic             clk_i,
   input  logic             rst_n_i,
   input  logic             up_i,
   input  logic             down_i,
   input  logic             coarse_i,
   input  logic             preset_i,
   output logic [FTW_W-1:0] ftw_o,
   output logic [HZ_W-1:0]  freq_hz_o,
   output logic             at_min_o,
   output logic             at_max_o,
   output logic             upd_o
);

   localparam int NSTEPS = calc_nsteps(MIN_HZ, MAX_HZ, STEP_HZ);
   // Wide enough that idx + coarse step never wraps before the clamp test.
   localparam int IDX_W  = $clog2(NSTEPS + COARSE_MUL + 1);

   localparam logic [IDX_W-1:0] C_NSTEPS   = IDX_W'(NSTEPS);
   localparam logic [IDX_W-1:0] C_FINE     = IDX_W'(1);
   localparam logic [IDX_W-1:0] C_COARSE   = IDX_W'(COARSE_MUL);
   // Bound values are elaboration-time constants; only adders run at runtime.
   localparam logic [FTW_W-1:0] C_MIN_FTW  = FTW_W'(MIN_FTW);
   localparam logic [FTW_W-1:0] C_MAX_FTW  = FTW_W'(MIN_FTW + NSTEPS * STEP_FTW);
   localparam logic [FTW_W-1:0] C_FTW_FINE = FTW_W'(STEP_FTW);
   localparam logic [FTW_W-1:0] C_FTW_CRS  = FTW_W'(STEP_FTW * COARSE_MUL);
   localparam logic [HZ_W-1:0]  C_MIN_HZ   = HZ_W'(MIN_HZ);
   localparam logic [HZ_W-1:0]  C_MAX_HZ   = HZ_W'(MAX_HZ);
   localparam logic [HZ_W-1:0]  C_HZ_FINE  = HZ_W'(STEP_HZ);
   localparam logic [HZ_W-1:0]  C_HZ_CRS   = HZ_W'(STEP_HZ * COARSE_MUL);

   logic w_step_up, w_step_dn;

   key_repeat #(
      .HOLD_CYC   (HOLD_CYC),
      .REPEAT_CYC (REPEAT_CYC)
   ) u_key_repeat (
      .clk_i     (clk_i),
      .rst_n_i   (rst_n_i),
      .up_i      (up_i),
      .down_i    (down_i),
      .preset_i  (preset_i),
      .step_up_o (w_step_up),
      .step_dn_o (w_step_dn)
   );

   logic [IDX_W-1:0] r_idx, w_idx_next;
   logic [FTW_W-1:0] r_ftw, w_ftw_next;
   logic [HZ_W-1:0]  r_hz, w_hz_next;
   logic             r_at_min, r_at_max, r_upd;
   logic             w_chg;
   logic [IDX_W-1:0] w_step, w_sum;
   logic [FTW_W-1:0] w_ftw_inc;
   logic [HZ_W-1:0]  w_hz_inc;

   always_comb begin
      w_step     = coarse_i ? C_COARSE  : C_FINE;
      w_ftw_inc  = coarse_i ? C_FTW_CRS : C_FTW_FINE;
      w_hz_inc   = coarse_i ? C_HZ_CRS  : C_HZ_FINE;
      w_sum      = r_idx + w_step;
      w_idx_next = r_idx;
      w_ftw_next = r_ftw;
      w_hz_next  = r_hz;
      w_chg      = 1'b0;
      if (preset_i) begin
         w_idx_next = '0;
         w_ftw_next = C_MIN_FTW;
         w_hz_next  = C_MIN_HZ;
         w_chg      = (r_idx != '0);
      end else if (w_step_up && (r_idx != C_NSTEPS)) begin
         w_chg = 1'b1;
         if (w_sum >= C_NSTEPS) begin
            // Land exactly on the top bound instead of accumulating past it.
            w_idx_next = C_NSTEPS;
            w_ftw_next = C_MAX_FTW;
            w_hz_next  = C_MAX_HZ;
         end else begin
            w_idx_next = w_sum;
            w_ftw_next = r_ftw + w_ftw_inc;
            w_hz_next  = r_hz + w_hz_inc;
         end
      end else if (w_step_dn && (r_idx != '0)) begin
         w_chg = 1'b1;
         if (r_idx <= w_step) begin
            w_idx_next = '0;
            w_ftw_next = C_MIN_FTW;
            w_hz_next  = C_MIN_HZ;
         end else begin
            w_idx_next = r_idx - w_step;
            w_ftw_next = r_ftw - w_ftw_inc;
            w_hz_next  = r_hz - w_hz_inc;
         end
      end
   end

   always_ff @(posedge clk_i or negedge rst_n_i) begin
      if (!rst_n_i) begin
         r_idx    <= '0;
         r_ftw    <= C_MIN_FTW;
         r_hz     <= C_MIN_HZ;
         r_at_min <= 1'b1;
         r_at_max <= 1'b0;
         r_upd    <= 1'b0;
      end else begin
         r_idx    <= w_idx_next;
         r_ftw    <= w_ftw_next;
         r_hz     <= w_hz_next;
         r_at_min <= (w_idx_next == '0);
         r_at_max <= (w_idx_next == C_NSTEPS);
         r_upd    <= w_chg;
      end
   end

   assign ftw_o     = r_ftw;
   assign freq_hz_o = r_hz;
   assign at_min_o  = r_at_min;
   assign at_max_o  = r_at_max;
   assign upd_o     = r_upd;

endmodule

// File: tb/tb_freq_stepper.sv
// -----------------------------------------------------------------------------
// tb_freq_stepper
// Directed, self-checking bench for freq_stepper with short hold/repeat
// timing (HOLD_CYC=10, REPEAT_CYC=4). Inputs change and outputs are sampled
// on the falling edge; the design acts on the rising edge.
// -----------------------------------------------------------------------------
module tb_freq_stepper;

   logic        clk_i = 1'b0;
   logic        rst_n_i;
   logic        up_i, down_i, coarse_i, preset_i;
   logic [31:0] ftw_o;
   logic [19:0] freq_hz_o;
   logic        at_min_o, at_max_o, upd_o;

   int n_checks = 0;
   int n_fail   = 0;
   int upd_cnt  = 0;
   int tick_no  = 0;
   int upd_ticks[$];

   always #5 clk_i = ~clk_i;

   freq_stepper #(
      .HOLD_CYC   (10),
      .REPEAT_CYC (4)
   ) dut (
      .clk_i     (clk_i),
      .rst_n_i   (rst_n_i),
      .up_i      (up_i),
      .down_i    (down_i),
      .coarse_i  (coarse_i),
      .preset_i  (preset_i),
      .ftw_o     (ftw_o),
      .freq_hz_o (freq_hz_o),
      .at_min_o  (at_min_o),
      .at_max_o  (at_max_o),
      .upd_o     (upd_o)
   );

   // Advance n cycles, sampling at the falling edge and logging upd_o pulses.
   task automatic tick(input int n);
      for (int i = 0; i < n; i++) begin
         @(posedge clk_i);
         @(negedge clk_i);
         tick_no++;
         if (upd_o === 1'b1) begin
            upd_cnt++;
            upd_ticks.push_back(tick_no);
         end
      end
   endtask

   // Short key tap: well under the hold time, so exactly one step.
   task automatic press(input logic dir_up);
      if (dir_up) up_i = 1'b1; else down_i = 1'b1;
      tick(2);
      up_i   = 1'b0;
      down_i = 1'b0;
      tick(3);
      $display("press %s coarse=%0b -> hz=%0d ftw=%0d", dir_up ? "up" : "down",
               coarse_i, freq_hz_o, ftw_o);
   endtask

   task automatic do_preset();
      preset_i = 1'b1;
      tick(1);
      preset_i = 1'b0;
      tick(2);
      $display("preset -> hz=%0d", freq_hz_o);
   endtask

   task automatic test_reset();
      rst_n_i = 1'b0; up_i = 1'b0; down_i = 1'b0; coarse_i = 1'b0; preset_i = 1'b0;
      tick(2);
      n_checks++;
      if (ftw_o !== 32'd1717987) begin n_fail++; $display("FAIL reset_ftw: got %0d expected 1717987", ftw_o); end
      n_checks++;
      if (freq_hz_o !== 20'd20000) begin n_fail++; $display("FAIL reset_hz: got %0d expected 20000", freq_hz_o); end
      n_checks++;
      if (at_min_o !== 1'b1 || at_max_o !== 1'b0) begin n_fail++; $display("FAIL reset_flags: got min=%b max=%b expected min=1 max=0", at_min_o, at_max_o); end
      n_checks++;
      if (upd_o !== 1'b0) begin n_fail++; $display("FAIL reset_upd: got %b expected 0", upd_o); end
      rst_n_i = 1'b1;
      tick(2);
      $display("reset released -> hz=%0d", freq_hz_o);
   endtask

   task automatic test_single_step();
      upd_cnt = 0;
      up_i = 1'b1;
      tick(3);
      up_i = 1'b0;
      tick(3);
      $display("up held 3 cycles -> hz=%0d ftw=%0d upd_pulses=%0d", freq_hz_o, ftw_o, upd_cnt);
      n_checks++;
      if (ftw_o !== 32'd1889786) begin n_fail++; $display("FAIL single_ftw: got %0d expected 1889786", ftw_o); end
      n_checks++;
      if (freq_hz_o !== 20'd22000) begin n_fail++; $display("FAIL single_hz: got %0d expected 22000", freq_hz_o); end
      n_checks++;
      if (upd_cnt != 1) begin n_fail++; $display("FAIL single_upd: got %0d pulses expected 1", upd_cnt); end
      n_checks++;
      if (at_min_o !== 1'b0) begin n_fail++; $display("FAIL single_at_min: got %b expected 0", at_min_o); end
   endtask

   task automatic test_coarse_up();
      int exp_hz[4]  = '{30000, 40000, 50000, 50000};
      int exp_ftw[4] = '{2576982, 3435977, 4294972, 4294972};
      int exp_upd[4] = '{1, 1, 1, 0};
      do_preset();
      coarse_i = 1'b1;
      for (int k = 0; k < 4; k++) begin
         upd_cnt = 0;
         press(1'b1);
         n_checks++;
         if (freq_hz_o !== 20'(exp_hz[k])) begin n_fail++; $display("FAIL coarse_up_hz[%0d]: got %0d expected %0d", k, freq_hz_o, exp_hz[k]); end
         n_checks++;
         if (ftw_o !== 32'(exp_ftw[k])) begin n_fail++; $display("FAIL coarse_up_ftw[%0d]: got %0d expected %0d", k, ftw_o, exp_ftw[k]); end
         n_checks++;
         if (upd_cnt != exp_upd[k]) begin n_fail++; $display("FAIL coarse_up_upd[%0d]: got %0d pulses expected %0d", k, upd_cnt, exp_upd[k]); end
      end
      n_checks++;
      if (at_max_o !== 1'b1 || at_min_o !== 1'b0) begin n_fail++; $display("FAIL coarse_up_flags: got max=%b min=%b expected max=1 min=0", at_max_o, at_min_o); end
      coarse_i = 1'b0;
   endtask

   task automatic test_coarse_down_clamp();
      do_preset();
      coarse_i = 1'b0;
      press(1'b1);
      n_checks++;
      if (freq_hz_o !== 20'd22000) begin n_fail++; $display("FAIL clamp_dn_start: got %0d expected 22000", freq_hz_o); end
      coarse_i = 1'b1;
      upd_cnt = 0;
      press(1'b0);
      n_checks++;
      if (freq_hz_o !== 20'd20000) begin n_fail++; $display("FAIL clamp_dn_hz: got %0d expected 20000", freq_hz_o); end
      n_checks++;
      if (ftw_o !== 32'd1717987) begin n_fail++; $display("FAIL clamp_dn_ftw: got %0d expected 1717987", ftw_o); end
      n_checks++;
      if (at_min_o !== 1'b1) begin n_fail++; $display("FAIL clamp_dn_at_min: got %b expected 1", at_min_o); end
      n_checks++;
      if (upd_cnt != 1) begin n_fail++; $display("FAIL clamp_dn_upd: got %0d pulses expected 1", upd_cnt); end
      coarse_i = 1'b0;
   endtask

   task automatic test_auto_repeat();
      int exp_ticks[4] = '{2, 12, 16, 20};
      do_preset();
      upd_ticks.delete();
      tick_no = 0;
      up_i = 1'b1;
      tick(20);
      up_i = 1'b0;
      tick(10);
      $display("up held 20 cycles -> hz=%0d steps=%0d", freq_hz_o, upd_ticks.size());
      n_checks++;
      if (upd_ticks.size() != 4) begin n_fail++; $display("FAIL repeat_count: got %0d steps expected 4", upd_ticks.size()); end
      for (int k = 0; k < 4; k++) begin
         n_checks++;
         if (k >= upd_ticks.size()) begin
            n_fail++; $display("FAIL repeat_tick[%0d]: got none expected %0d", k, exp_ticks[k]);
         end else if (upd_ticks[k] != exp_ticks[k]) begin
            n_fail++; $display("FAIL repeat_tick[%0d]: got %0d expected %0d", k, upd_ticks[k], exp_ticks[k]);
         end
      end
      n_checks++;
      if (freq_hz_o !== 20'd28000) begin n_fail++; $display("FAIL repeat_hz: got %0d expected 28000", freq_hz_o); end
   endtask

   task automatic test_lock();
      do_preset();
      upd_cnt = 0;
      up_i = 1'b1; down_i = 1'b1;
      tick(3);
      down_i = 1'b0;
      tick(14);
      up_i = 1'b0;
      tick(2);
      $display("both keys then down released -> hz=%0d upd_pulses=%0d", freq_hz_o, upd_cnt);
      n_checks++;
      if (upd_cnt != 0) begin n_fail++; $display("FAIL lock_upd: got %0d pulses expected 0", upd_cnt); end
      n_checks++;
      if (freq_hz_o !== 20'd20000) begin n_fail++; $display("FAIL lock_hz: got %0d expected 20000", freq_hz_o); end
      upd_cnt = 0;
      press(1'b1);
      n_checks++;
      if (freq_hz_o !== 20'd22000 || upd_cnt != 1) begin n_fail++; $display("FAIL lock_exit: got hz=%0d pulses=%0d expected hz=22000 pulses=1", freq_hz_o, upd_cnt); end
   endtask

   task automatic test_preset_held();
      do_preset();
      for (int k = 0; k < 7; k++) press(1'b1);
      up_i = 1'b1;
      tick(3);
      n_checks++;
      if (freq_hz_o !== 20'd36000) begin n_fail++; $display("FAIL preset_start: got %0d expected 36000", freq_hz_o); end
      preset_i = 1'b1;
      tick(1);
      $display("preset with up held -> hz=%0d upd=%b", freq_hz_o, upd_o);
      n_checks++;
      if (freq_hz_o !== 20'd20000 || ftw_o !== 32'd1717987) begin n_fail++; $display("FAIL preset_value: got hz=%0d ftw=%0d expected hz=20000 ftw=1717987", freq_hz_o, ftw_o); end
      n_checks++;
      if (upd_o !== 1'b1) begin n_fail++; $display("FAIL preset_upd: got %b expected 1", upd_o); end
      preset_i = 1'b0;
      upd_cnt = 0;
      tick(15);
      n_checks++;
      if (upd_cnt != 0 || freq_hz_o !== 20'd20000) begin n_fail++; $display("FAIL preset_lock: got hz=%0d pulses=%0d expected hz=20000 pulses=0", freq_hz_o, upd_cnt); end
      up_i = 1'b0;
      tick(3);
      press(1'b1);
      n_checks++;
      if (freq_hz_o !== 20'd22000) begin n_fail++; $display("FAIL preset_after: got %0d expected 22000", freq_hz_o); end
   endtask

   task automatic test_reset_mid_hold();
      do_preset();
      up_i = 1'b1;
      tick(12);
      n_checks++;
      if (freq_hz_o !== 20'd24000) begin n_fail++; $display("FAIL midhold_pre: got %0d expected 24000", freq_hz_o); end
      rst_n_i = 1'b0;
      #1;
      $display("async reset mid-hold -> hz=%0d ftw=%0d", freq_hz_o, ftw_o);
      n_checks++;
      if (freq_hz_o !== 20'd20000 || ftw_o !== 32'd1717987) begin n_fail++; $display("FAIL midhold_value: got hz=%0d ftw=%0d expected hz=20000 ftw=1717987", freq_hz_o, ftw_o); end
      n_checks++;
      if (upd_o !== 1'b0 || at_min_o !== 1'b1) begin n_fail++; $display("FAIL midhold_flags: got upd=%b min=%b expected upd=0 min=1", upd_o, at_min_o); end
      up_i = 1'b0;
      tick(2);
      rst_n_i = 1'b1;
      tick(2);
      upd_cnt = 0;
      press(1'b1);
      n_checks++;
      if (freq_hz_o !== 20'd22000 || upd_cnt != 1) begin n_fail++; $display("FAIL midhold_after: got hz=%0d pulses=%0d expected hz=22000 pulses=1", freq_hz_o, upd_cnt); end
   endtask

   initial begin
      test_reset();
      test_single_step();
      test_coarse_up();
      test_coarse_down_clamp();
      test_auto_repeat();
      test_lock();
      test_preset_held();
      test_reset_mid_hold();
      $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
      $finish;
   end

endmodule
